popcount_unary_serializer: RTL and testbench
============================================

Name: popcount_unary_serializer

Overview:
- Inverse of the popcount cores: takes a count C and generates an N_IN-bit stream with exactly C ones.
- Streams the bits serially under a valid/ready handshake and also assembles them into a parallel vector.
- Used as a stimulus and reference source for popcount-based ternary neurons, e.g. count -> 31-bit vector -> approximate popcount -> error check.
- Sits between the count-generation logic and the popcount DUT input register.

Parameters:
- N_IN, 31: stream and vector length in bits. Must be at least 2.
- CW, 5: count width; equals $clog2(N_IN+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cnt_valid  in  1  cnt_in is valid.
- cnt_ready  out  1  block can accept a count.
- cnt_in  in  CW  requested number of ones.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  downstream accepts bit_out.
- bit_out  out  1  current stream bit.
- bit_last  out  1  marks beat N_IN-1 of the current vector.
- vec_out  out  N_IN  assembled vector; bit i is stream beat i.
- vec_valid  out  1  one-cycle pulse when vec_out is complete.

Behaviour:
- Reset values:
  - state = IDLE.
  - cnt_ready = 1.
  - bit_valid, bit_out, bit_last, vec_valid = 0.
  - vec_out = 0.
  - Internal idx, acc, cnt_q = 0.
- Reset takes effect immediately when asserted, including mid-stream. The partial vector is discarded. No vec_valid pulse follows reset.
- FSM states: IDLE and EMIT.
- IDLE:
  - cnt_ready = 1 and bit_valid = 0.
  - On cnt_valid & cnt_ready:
    - cnt_q <= min(cnt_in, N_IN) (saturating).
    - idx <= 0, acc <= 0.
    - state <= EMIT.
- EMIT:
  - cnt_ready = 0 and bit_valid = 1.
  - bit_out is a combinational function of idx, acc and cnt_q (see Optional Feature). It is stable while a beat is stalled.
  - bit_last = (idx == N_IN-1).
  - On bit_valid & bit_ready:
    - vec_out[idx] <= bit_out.
    - acc updates.
    - idx <= idx+1.
    - On the beat where bit_last = 1: state <= IDLE, and vec_valid pulses 1 in the following cycle.
- Latency:
  - Count accepted at edge k: first bit_valid is high in cycle k+1.
  - With bit_ready held at 1, vec_valid is high in cycle k+N_IN+1.
  - One IDLE cycle (cnt_ready = 1) separates consecutive vectors.
- vec_out:
  - Cleared to 0 when a new count is accepted.
  - Otherwise holds its value until the next accept.
- Backpressure: with bit_ready = 0, idx, acc and bit_out hold and bit_valid stays high.
- Invariant: popcount(vec_out) == cnt_q at every vec_valid pulse, for all cnt_q in 0..N_IN.
- idx width is CW. It never wraps inside EMIT because it is reset on accept.
- cnt_valid is ignored while in EMIT. The producer holds cnt_valid/cnt_in until it sees cnt_ready.

Optional Feature:
- Macro: POPCOUNT_SPREAD_EN.
- Defined (spread mode, Bresenham):
  - s = acc + cnt_q, computed CW+1 bits wide.
  - bit_out = (s >= N_IN).
  - On handshake: acc <= bit_out ? s - N_IN : s.
  - Ones are distributed evenly, with the last one always on beat N_IN-1 when cnt_q > 0.
- Undefined (thermometer mode):
  - bit_out = (idx < cnt_q).
  - acc is unused and stays at 0.
- Both modes must satisfy the popcount invariant.

Test Plan:
- cnt_in=0, bit_ready=1 -> 31 beats of bit_out=0; bit_last only on beat 30; vec_valid pulse with vec_out=0x00000000. Both modes.
- cnt_in=31, bit_ready=1 -> 31 ones; vec_out=0x7FFFFFFF; vec_valid exactly at accept cycle + 32.
- Thermometer mode, cnt_in=5 -> beats 0-4 = 1, rest 0; vec_out=0x0000001F. Spread mode, cnt_in=1 -> single one at beat 30; vec_out=0x40000000.
- Spread mode, cnt_in=16, bit_ready toggling 1,0,0,1 -> bit_out and bit_valid stable during stalls; 16 ones total; final vec_out matches the zero-stall run.
- Sweep cnt_in 0..31 back-to-back in both modes -> popcount(vec_out)==cnt_in each time, checked against an exact popcount; cnt_ready high for exactly one cycle between vectors.
- rst asserted at beat 10 of cnt_in=20 -> outputs return to reset values asynchronously; no vec_valid pulse; next count cnt_in=3 produces a correct vector.

Source files
------------

// File: rtl/popcount_unary_serializer.sv
// popcount_unary_serializer
// Turns a requested count C into an N_IN-beat bit stream containing exactly C
// ones. The stream is emitted under a valid/ready handshake, and the beats are
// also collected into a parallel vector that is flagged with a one-cycle
// vec_valid pulse once the final beat has been accepted.
//
// Build option:
//   POPCOUNT_SPREAD_EN defined   -> spread mode: the ones are distributed evenly
//                                   over the vector with a Bresenham accumulator,
//                                   and the last one always lands on beat N_IN-1.
//   POPCOUNT_SPREAD_EN undefined -> thermometer mode: the ones occupy beats
//                                   0..C-1 and the accumulator does not exist.
module popcount_unary_serializer #(
    parameter int N_IN = 31,
    parameter int CW   = $clog2(N_IN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cnt_valid,
    output logic            cnt_ready,
    input  logic [CW-1:0]   cnt_in,
    output logic            bit_valid,
    input  logic            bit_ready,
    output logic            bit_out,
    output logic            bit_last,
    output logic [N_IN-1:0] vec_out,
    output logic            vec_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // N_IN in the widths used by the beat index and the spread accumulator sum
    localparam logic [CW:0]   N_WIDE   = (CW + 1)'(N_IN);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_IN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     idx_nxt;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_nxt;
    logic [N_IN-1:0]   vec_nxt;
    logic              done_nxt;
    logic              beat_bit;
    logic              last_beat;

`ifdef POPCOUNT_SPREAD_EN
    logic [CW-1:0]     acc;
    logic [CW-1:0]     acc_nxt;
    logic [CW-1:0]     acc_step;
    logic [CW:0]       spread_sum;
    logic [CW:0]       spread_wrap;
`endif

    // Requests above N_IN are clamped so the vector never asks for more ones
    // than it has beats.
    function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
        logic [CW:0] c_wide;
        c_wide = {1'b0, c};
        if (c_wide > N_WIDE) begin
            return LAST_IDX + CW'(1);
        end
        return c;
    endfunction

`ifdef POPCOUNT_SPREAD_EN
    // Bresenham step: a one is emitted whenever the running sum crosses N_IN,
    // and the remainder is carried into the next beat. The accumulator stays
    // below N_IN, so the sum fits in CW+1 bits and the remainder in CW bits.
    always_comb begin
        spread_sum  = {1'b0, acc} + {1'b0, cnt_q};
        spread_wrap = spread_sum - N_WIDE;
        beat_bit    = (spread_sum >= N_WIDE);
        acc_step    = beat_bit ? spread_wrap[CW-1:0] : spread_sum[CW-1:0];
    end
`else
    // Thermometer code: the first cnt_q beats are ones, the rest zeros.
    always_comb begin
        beat_bit = (idx < cnt_q);
    end
`endif

    // Next-state and handshake outputs; the beat value depends only on
    // registered state, so it holds steady while the beat is stalled.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt_q;
        vec_nxt   = vec_out;
        done_nxt  = 1'b0;
`ifdef POPCOUNT_SPREAD_EN
        acc_nxt   = acc;
`endif
        cnt_ready = 1'b0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        bit_last  = 1'b0;
        last_beat = (idx == LAST_IDX);

        case (state)
            IDLE: begin
                cnt_ready = 1'b1;
                if (cnt_valid) begin
                    cnt_nxt   = sat_count(cnt_in);
                    idx_nxt   = '0;
                    vec_nxt   = '0;
`ifdef POPCOUNT_SPREAD_EN
                    acc_nxt   = '0;
`endif
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                bit_valid = 1'b1;
                bit_out   = beat_bit;
                bit_last  = last_beat;
                if (bit_ready) begin
                    idx_nxt = idx + CW'(1);
`ifdef POPCOUNT_SPREAD_EN
                    acc_nxt = acc_step;
`endif
                    for (int i = 0; i < N_IN; i++) begin
                        if (idx == CW'(i)) begin
                            vec_nxt[i] = beat_bit;
                        end
                    end
                    if (last_beat) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register; reset drops any stream in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat index, latched count, assembled vector and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            cnt_q     <= '0;
            vec_out   <= '0;
            vec_valid <= 1'b0;
        end else begin
            idx       <= idx_nxt;
            cnt_q     <= cnt_nxt;
            vec_out   <= vec_nxt;
            vec_valid <= done_nxt;
        end
    end

`ifdef POPCOUNT_SPREAD_EN
    // Spread accumulator (remainder of beats * cnt_q modulo N_IN).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_popcount_unary_serializer.sv
// Self-checking bench for popcount_unary_serializer. Builds in the same mode
// as the design (POPCOUNT_SPREAD_EN selects spread mode).
module tb_popcount_unary_serializer;

    localparam int N  = 31;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cnt_valid = 1'b0;
    logic          cnt_ready;
    logic [CW-1:0] cnt_in = '0;
    logic          bit_valid;
    logic          bit_ready = 1'b0;
    logic          bit_out;
    logic          bit_last;
    logic [N-1:0]  vec_out;
    logic          vec_valid;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    popcount_unary_serializer #(.N_IN(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .cnt_in    (cnt_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_out   (bit_out),
        .bit_last  (bit_last),
        .vec_out   (vec_out),
        .vec_valid (vec_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: beat i of a vector holding c ones.
    // Spread: a one wherever floor(i*c/N) steps up, which places ones evenly
    // and puts the last one on beat N-1. Thermometer: ones on beats 0..c-1.
    function automatic logic model_bit(input int c, input int i);
        int cs;
        cs = (c > N) ? N : c;
`ifdef POPCOUNT_SPREAD_EN
        return (((i + 1) * cs) / N) != ((i * cs) / N);
`else
        return i < cs;
`endif
    endfunction

    function automatic logic [31:0] model_vec(input int c);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = model_bit(c, i);
        return v;
    endfunction

    // Issue count c at the current falling edge and follow the whole vector.
    // stall_mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random.
    // Returns at the falling edge of the vec_valid cycle, so a following call
    // presents its count in the single IDLE cycle (back-to-back).
    task automatic run_vector(input int c, input int stall_mode);
        int beat   = 0;
        int n      = 0;
        int stalls = 0;
        logic r;
        logic [31:0] exp_vec;
        exp_vec   = model_vec(c);
        cnt_in    = CW'(c);
        cnt_valid = 1'b1;
        check("cnt_ready_idle", {31'b0, cnt_ready}, 32'd1);
        @(posedge clk);
        while (beat < N && n < 4 * N + 8) begin
            @(negedge clk);
            n++;
            cnt_valid = 1'b0;
            check($sformatf("bit_valid c=%0d b=%0d", c, beat), {31'b0, bit_valid}, 32'd1);
            check($sformatf("cnt_ready_busy c=%0d", c), {31'b0, cnt_ready}, 32'd0);
            check($sformatf("vec_valid_busy c=%0d", c), {31'b0, vec_valid}, 32'd0);
            check($sformatf("bit_out c=%0d b=%0d", c, beat), {31'b0, bit_out}, {31'b0, model_bit(c, beat)});
            check($sformatf("bit_last c=%0d b=%0d", c, beat), {31'b0, bit_last}, {31'b0, (beat == N - 1)});
            case (stall_mode)
                1:       r = (((n - 1) % 4) == 0) || (((n - 1) % 4) == 3);
                2:       r = ($urandom_range(0, 3) != 0);
                default: r = 1'b1;
            endcase
            bit_ready = r;
            @(posedge clk);
            if (r) beat++;
            else stalls++;
        end
        if (beat < N) check($sformatf("beat_budget c=%0d", c), beat, N);
        @(negedge clk);
        n++;
        bit_ready = 1'b0;
        check($sformatf("vec_valid c=%0d", c), {31'b0, vec_valid}, 32'd1);
        check($sformatf("vec_out c=%0d", c), {1'b0, vec_out}, exp_vec);
        check($sformatf("popcount c=%0d", c), $countones(vec_out), (c > N) ? N : c);
        check($sformatf("cnt_ready_gap c=%0d", c), {31'b0, cnt_ready}, 32'd1);
        check($sformatf("latency c=%0d", c), n, N + stalls + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cnt_ready"}, {31'b0, cnt_ready}, 32'd1);
        check({tag, "_bit_valid"}, {31'b0, bit_valid}, 32'd0);
        check({tag, "_bit_out"},   {31'b0, bit_out},   32'd0);
        check({tag, "_bit_last"},  {31'b0, bit_last},  32'd0);
        check({tag, "_vec_valid"}, {31'b0, vec_valid}, 32'd0);
        check({tag, "_vec_out"},   {1'b0, vec_out},    32'd0);
    endtask

    initial begin
        // Power-on reset, checked asynchronously before any clock edge
        #1 rst = 1'b1;
        #2 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors: empty, full, small counts, stalled vs free-running
        run_vector(0, 0);
        run_vector(31, 0);
        run_vector(5, 0);
        run_vector(1, 0);
        run_vector(16, 1);
        run_vector(16, 0);

        // Back-to-back sweep of every count
        for (int c = 0; c <= N; c++) run_vector(c, 0);

        // Random counts under random backpressure
        for (int k = 0; k < 20; k++) run_vector($urandom_range(0, N), 2);

        // Reset in the middle of a cnt=20 vector, at beat 10
        cnt_in    = CW'(20);
        cnt_valid = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            cnt_valid = 1'b0;
            bit_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        check("mid_bit_valid", {31'b0, bit_valid}, 32'd1);
        check("mid_bit_out", {31'b0, bit_out}, {31'b0, model_bit(20, 10)});
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_vec_valid", {31'b0, vec_valid}, 32'd0);
            check("post_rst_bit_valid", {31'b0, bit_valid}, 32'd0);
        end
        run_vector(3, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
